nvm_seq_ctrl: RTL and testbench
===============================

// Module: nvm_seq_ctrl
// PURPOSE
// Parametrised sequencer between the generic memory interface (addr/data/op/region/op_valid)
// and an embedded NVM macro. Generalises a fixed 256x8 wrapper to any width/depth.
// Adds per-operation timing counters, sector/mass erase, info-block write protection,
// range checking and a busy/error handshake. Sits between the system bus bridge and the macro.
// PARAMETERS
// NBW_DATA     8     data width, bits
// NBW_ADDR     8     address width, bits
// DEPTH        256   words per region; legal addresses 0..DEPTH-1
// SECTOR_WORDS 16    words per erase sector, power of 2
// READ_CYC     2     macro access cycles for READ, >=1
// PROG_CYC     20    macro access cycles for PROGRAM, >=1
// ERASE_CYC    200   macro access cycles for SECTOR/MASS erase, >=1
// INFO_WR_EN   0     1: program/erase allowed on info block (region 1)
// PORTS
// clk          in   1         system clock, rising edge
// rst_async    in   1         asynchronous reset, active-high
// i_addr       in   NBW_ADDR  word address
// i_data       in   NBW_DATA  program data
// i_op         in   4         1=READ 2=PROGRAM 3=SECTOR_ERASE 4=MASS_ERASE, others illegal
// i_region     in   1         0 main array, 1 information block
// i_op_valid   in   1         request strobe
// o_data       out  NBW_DATA  read data, held until next READ completes
// o_valid      out  1         one-cycle completion pulse
// o_error      out  1         qualifies o_valid: request rejected, macro untouched
// o_busy       out  1         high whenever state != IDLE
// o_mem_ce     out  1         macro chip enable
// o_mem_we     out  1         macro program strobe
// o_mem_erase  out  2         macro erase: 01 sector, 10 mass, 00 none
// o_mem_region out  1         macro region select
// o_mem_addr   out  NBW_ADDR  macro address
// o_mem_din    out  NBW_DATA  macro write data
// i_mem_dout   in   NBW_DATA  macro read data, valid in last ACCESS cycle
// BEHAVIOUR
// - Reset: state IDLE, counter 0, all outputs 0 (o_data, o_valid, o_error, o_busy, o_mem_*).
// - Accept: edge where state==IDLE and i_op_valid=1. Op, addr, data and region are registered.
//   While busy, i_op_valid is ignored: no queueing, no error.
// - Rejection at accept: illegal op; addr>=DEPTH (except MASS_ERASE); or PROGRAM/erase with
//   region 1 and INFO_WR_EN=0. Next state is DONE with o_error=1. No macro strobe is asserted.
// - FSM: IDLE -> SETUP (1 cyc) -> ACCESS (N cyc) -> DONE (1 cyc) -> IDLE.
//   N = READ_CYC, PROG_CYC or ERASE_CYC, selected by the op.
// - SETUP: ce=1; addr, din and region are driven from registers. Strobes are still 0.
// - ACCESS: ce=1 plus the op strobe (we, or erase code). Down-counter is loaded with N-1 on
//   entry and leaves at 0. Width = clog2(max N).
// - SECTOR_ERASE: o_mem_addr has its low log2(SECTOR_WORDS) bits forced to 0.
//   MASS_ERASE: o_mem_addr = 0.
// - READ: o_data captures i_mem_dout at the edge that leaves ACCESS.
// - DONE: all o_mem_* are 0 and o_valid=1. o_busy stays 1 during DONE.
//   A new request is accepted on the first edge back in IDLE.
// - Latency: o_valid is high in the cycle after N+1 edges following accept.
//   Rejected requests: o_valid is high in the cycle directly after accept.
// - o_error=0 on successful completion. o_data is unchanged by non-READ ops and by errors.
// - Reset mid-operation: strobes drop immediately (async) and the op is abandoned.
//   No o_valid is produced.
// TESTING
// - READ_CYC=2, READ r0 addr 0x05, macro returns 0xA5 -> ce for 3 cyc, o_valid 4th cyc, o_data=0xA5, o_error=0.
// - PROGRAM addr 0x10 data 0x3C, PROG_CYC=20 -> o_mem_we high exactly 20 cyc, din=0x3C, o_valid after, o_error=0.
// - SECTOR_ERASE addr 0x27, SECTOR_WORDS=16 -> o_mem_addr=0x20, o_mem_erase=01 for ERASE_CYC cyc, o_valid.
// - PROGRAM region 1 with INFO_WR_EN=0; then op=0x7; then READ addr=DEPTH -> each o_valid+o_error next cyc, no ce.
// - i_op_valid held high during a PROGRAM -> second request dropped; first completes; next accepted only in IDLE.
// - rst_async pulsed mid-ERASE -> o_mem_erase=00 and o_busy=0 without clock, no o_valid; next READ works.

Source files
------------

// File: rtl/nvm_seq_ctrl.sv
// nvm_seq_ctrl: sequencer between the generic memory request interface and an
// embedded NVM macro. Each accepted request runs IDLE -> SETUP -> ACCESS(N) ->
// DONE -> IDLE; requests that fail legality checks go straight to DONE with
// o_error set, and the macro is never enabled for them.
//
// Ports
//   clk, rst_async           clock (rising edge), asynchronous active-high reset
//   i_addr/i_data/i_op/      request: word address, program data, opcode
//   i_region/i_op_valid      (1 READ, 2 PROGRAM, 3 SECTOR_ERASE, 4 MASS_ERASE),
//                            region (0 main, 1 info), request strobe
//   o_data                   last READ result, held until the next READ completes
//   o_valid/o_error          one-cycle completion pulse, error qualifier
//   o_busy                   high whenever the sequencer is not idle
//   o_mem_*                  macro controls: ce, we, erase code, region, addr, din
//   i_mem_dout               macro read data, valid in the last ACCESS cycle
module nvm_seq_ctrl #(
    parameter int unsigned NBW_DATA     = 8,
    parameter int unsigned NBW_ADDR     = 8,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned SECTOR_WORDS = 16,
    parameter int unsigned READ_CYC     = 2,
    parameter int unsigned PROG_CYC     = 20,
    parameter int unsigned ERASE_CYC    = 200,
    parameter int unsigned INFO_WR_EN   = 0
) (
    input  logic                clk,
    input  logic                rst_async,
    input  logic [NBW_ADDR-1:0] i_addr,
    input  logic [NBW_DATA-1:0] i_data,
    input  logic [3:0]          i_op,
    input  logic                i_region,
    input  logic                i_op_valid,
    output logic [NBW_DATA-1:0] o_data,
    output logic                o_valid,
    output logic                o_error,
    output logic                o_busy,
    output logic                o_mem_ce,
    output logic                o_mem_we,
    output logic [1:0]          o_mem_erase,
    output logic                o_mem_region,
    output logic [NBW_ADDR-1:0] o_mem_addr,
    output logic [NBW_DATA-1:0] o_mem_din,
    input  logic [NBW_DATA-1:0] i_mem_dout
);

    localparam logic [3:0] OP_READ  = 4'd1;
    localparam logic [3:0] OP_PROG  = 4'd2;
    localparam logic [3:0] OP_SERASE = 4'd3;
    localparam logic [3:0] OP_MERASE = 4'd4;

    localparam int unsigned MAX_RP = (READ_CYC > PROG_CYC) ? READ_CYC : PROG_CYC;
    localparam int unsigned MAX_N  = (MAX_RP > ERASE_CYC) ? MAX_RP : ERASE_CYC;
    localparam int unsigned CNT_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    localparam logic [NBW_ADDR-1:0] SEC_MASK = NBW_ADDR'(SECTOR_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t              state_q;
    logic [3:0]          op_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NBW_DATA-1:0] data_q;
    logic                valid_q;
    logic                error_q;
    logic                busy_q;
    logic                mem_ce_q;
    logic                mem_we_q;
    logic [1:0]          mem_erase_q;
    logic                mem_region_q;
    logic [NBW_ADDR-1:0] mem_addr_q;
    logic [NBW_DATA-1:0] mem_din_q;

    logic                reject_c;
    logic [NBW_ADDR-1:0] eff_addr_c;
    logic [CNT_W-1:0]    cnt_load_c;

    // Request legality and effective macro address, evaluated on the raw inputs at accept
    always_comb begin
        reject_c   = 1'b0;
        eff_addr_c = i_addr;
        case (i_op)
            OP_READ: begin
                reject_c = (32'(i_addr) >= DEPTH);
            end
            OP_PROG: begin
                reject_c = (32'(i_addr) >= DEPTH) || (i_region && (INFO_WR_EN == 0));
            end
            OP_SERASE: begin
                reject_c   = (32'(i_addr) >= DEPTH) || (i_region && (INFO_WR_EN == 0));
                eff_addr_c = i_addr & ~SEC_MASK;
            end
            OP_MERASE: begin
                reject_c   = i_region && (INFO_WR_EN == 0);
                eff_addr_c = '0;
            end
            default: reject_c = 1'b1;
        endcase
    end

    // Access length minus one for the registered op (counter exits ACCESS at zero)
    always_comb begin
        cnt_load_c = CNT_W'(ERASE_CYC - 1);
        if (op_q == OP_READ) begin
            cnt_load_c = CNT_W'(READ_CYC - 1);
        end else if (op_q == OP_PROG) begin
            cnt_load_c = CNT_W'(PROG_CYC - 1);
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            mem_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_erase_q  <= 2'b00;
            mem_region_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_op_valid) begin
                        op_q   <= i_op;
                        busy_q <= 1'b1;
                        if (reject_c) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b1;
                            error_q <= 1'b1;
                        end else begin
                            state_q      <= S_SETUP;
                            error_q      <= 1'b0;
                            mem_ce_q     <= 1'b1;
                            mem_region_q <= i_region;
                            mem_addr_q   <= eff_addr_c;
                            mem_din_q    <= i_data;
                        end
                    end
                end
                S_SETUP: begin
                    state_q  <= S_ACCESS;
                    cnt_q    <= cnt_load_c;
                    mem_we_q <= (op_q == OP_PROG);
                    if (op_q == OP_SERASE) begin
                        mem_erase_q <= 2'b01;
                    end else if (op_q == OP_MERASE) begin
                        mem_erase_q <= 2'b10;
                    end else begin
                        mem_erase_q <= 2'b00;
                    end
                end
                S_ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q      <= S_DONE;
                        valid_q      <= 1'b1;
                        mem_ce_q     <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_erase_q  <= 2'b00;
                        mem_region_q <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_din_q    <= '0;
                        if (op_q == OP_READ) begin
                            data_q <= i_mem_dout;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    error_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_error      = error_q;
    assign o_busy       = busy_q;
    assign o_mem_ce     = mem_ce_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_erase  = mem_erase_q;
    assign o_mem_region = mem_region_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_din    = mem_din_q;

endmodule

// File: tb/tb_nvm_seq_ctrl.sv
// tb_nvm_seq_ctrl: directed and random requests against nvm_seq_ctrl. Expected
// latency, strobe counts, macro address and read data come from a transaction
// level model of the request rules; the macro is a static random byte array.
module tb_nvm_seq_ctrl;

    localparam int unsigned DEPTH = 192;
    localparam int unsigned SECW  = 16;
    localparam int unsigned RCYC  = 2;
    localparam int unsigned PCYC  = 20;
    localparam int unsigned ECYC  = 200;

    logic       clk = 1'b0;
    logic       rst_async;
    logic [7:0] i_addr;
    logic [7:0] i_data;
    logic [3:0] i_op;
    logic       i_region;
    logic       i_op_valid;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_error;
    logic       o_busy;
    logic       o_mem_ce;
    logic       o_mem_we;
    logic [1:0] o_mem_erase;
    logic       o_mem_region;
    logic [7:0] o_mem_addr;
    logic [7:0] o_mem_din;
    logic [7:0] i_mem_dout;

    logic [7:0] mem [512];
    logic [7:0] exp_data;
    int total = 0;
    int bad   = 0;

    nvm_seq_ctrl #(
        .NBW_DATA(8), .NBW_ADDR(8), .DEPTH(DEPTH), .SECTOR_WORDS(SECW),
        .READ_CYC(RCYC), .PROG_CYC(PCYC), .ERASE_CYC(ECYC), .INFO_WR_EN(0)
    ) dut (
        .clk(clk), .rst_async(rst_async),
        .i_addr(i_addr), .i_data(i_data), .i_op(i_op), .i_region(i_region),
        .i_op_valid(i_op_valid),
        .o_data(o_data), .o_valid(o_valid), .o_error(o_error), .o_busy(o_busy),
        .o_mem_ce(o_mem_ce), .o_mem_we(o_mem_we), .o_mem_erase(o_mem_erase),
        .o_mem_region(o_mem_region), .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din),
        .i_mem_dout(i_mem_dout)
    );

    always #5 clk = ~clk;

    // Macro model: read data looked up from region/address while enabled
    assign i_mem_dout = mem[{o_mem_region, o_mem_addr}];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to completion against the model
    task automatic run_op(input logic [3:0] op, input logic [7:0] addr, input logic [7:0] data,
                          input logic region, input bit hold);
        bit         rej;
        int         n;
        int         k;
        int         ce_n;
        int         we_n;
        int         er_n;
        int         er_ok;
        int         bad_bus;
        int         idle_n;
        bit         seen;
        logic [7:0] eaddr;
        logic [1:0] ecode;
        logic       err_s;
        logic [7:0] data_s;

        rej   = !(op >= 4'd1 && op <= 4'd4)
              || (op != 4'd4 && int'(addr) >= int'(DEPTH))
              || (op >= 4'd2 && op <= 4'd4 && region == 1'b1);
        n     = (op == 4'd1) ? int'(RCYC) : (op == 4'd2) ? int'(PCYC) : int'(ECYC);
        eaddr = (op == 4'd3) ? 8'((int'(addr) / int'(SECW)) * int'(SECW))
              : (op == 4'd4) ? 8'd0 : addr;
        ecode = (op == 4'd3) ? 2'b01 : (op == 4'd4) ? 2'b10 : 2'b00;

        @(negedge clk);
        i_op = op; i_addr = addr; i_data = data; i_region = region; i_op_valid = 1'b1;
        @(posedge clk);
        k = 0; seen = 0; ce_n = 0; we_n = 0; er_n = 0; er_ok = 0; bad_bus = 0; idle_n = 0;
        err_s = 1'b0; data_s = 8'h00;
        while (!seen && k < 400) begin
            @(negedge clk);
            k++;
            if (!hold) i_op_valid = 1'b0;
            ce_n += int'(o_mem_ce);
            we_n += int'(o_mem_we);
            if (o_mem_erase != 2'b00) er_n++;
            if (o_mem_erase == ecode && ecode != 2'b00) er_ok++;
            if (!o_busy) idle_n++;
            if (o_mem_ce && (o_mem_addr !== eaddr || o_mem_region !== region
                             || (op == 4'd2 && o_mem_din !== data))) bad_bus++;
            if (o_valid) begin
                seen = 1; err_s = o_error; data_s = o_data;
            end
        end
        if (!rej && op == 4'd1) exp_data = mem[{region, addr}];

        check("valid_seen", 32'(seen), 32'd1);
        check("latency", 32'(k), rej ? 32'd1 : 32'(n + 2));
        check("error", 32'(err_s), 32'(rej));
        check("data", 32'(data_s), 32'(exp_data));
        check("ce_cycles", 32'(ce_n), rej ? 32'd0 : 32'(n + 1));
        check("we_cycles", 32'(we_n), (!rej && op == 4'd2) ? 32'(n) : 32'd0);
        check("erase_cycles", 32'(er_n), (!rej && ecode != 2'b00) ? 32'(n) : 32'd0);
        check("erase_code_cycles", 32'(er_ok), (!rej && ecode != 2'b00) ? 32'(n) : 32'd0);
        check("bus_values", 32'(bad_bus), 32'd0);
        check("busy_during_op", 32'(idle_n), 32'd0);

        @(negedge clk);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_valid", 32'(o_valid), 32'd0);
        if (hold) begin
            // Held strobe: nothing was queued, the request is taken only now from IDLE
            @(negedge clk);
            check("hold_reaccept_busy", 32'(o_busy), 32'd1);
            check("hold_reaccept_ce", 32'(o_mem_ce), rej ? 32'd0 : 32'd1);
            i_op_valid = 1'b0;
            k = 0; seen = 0;
            while (!seen && k < 400) begin
                @(negedge clk);
                k++;
                if (o_valid) seen = 1;
            end
            check("hold_second_done", 32'(seen), 32'd1);
            check("hold_second_latency", 32'(k), rej ? 32'd0 : 32'(n + 1));
            @(negedge clk);
        end
    endtask

    initial begin
        int vcount;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        mem[5] = 8'hA5;
        exp_data   = 8'h00;
        rst_async  = 1'b1;
        i_addr = 8'h00; i_data = 8'h00; i_op = 4'h0; i_region = 1'b0; i_op_valid = 1'b0;
        #1;
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_flags", 32'({o_valid, o_error, o_busy}), 32'd0);
        check("rst_mem", 32'({o_mem_ce, o_mem_we, o_mem_erase, o_mem_region, o_mem_addr, o_mem_din}), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_async = 1'b0;

        run_op(4'd1, 8'h05, 8'h00, 1'b0, 1'b0);
        check("read_a5", 32'(o_data), 32'hA5);
        run_op(4'd2, 8'h10, 8'h3C, 1'b0, 1'b0);
        run_op(4'd3, 8'h27, 8'h00, 1'b0, 1'b0);
        run_op(4'd2, 8'h10, 8'h11, 1'b1, 1'b0);
        run_op(4'd7, 8'h10, 8'h11, 1'b0, 1'b0);
        run_op(4'd1, 8'(DEPTH), 8'h00, 1'b0, 1'b0);
        run_op(4'd1, 8'(DEPTH - 1), 8'h00, 1'b1, 1'b0);
        run_op(4'd4, 8'hFF, 8'h00, 1'b0, 1'b0);
        run_op(4'd2, 8'h20, 8'h77, 1'b0, 1'b1);

        // Reset during a sector erase: strobes drop without a clock edge
        @(negedge clk);
        i_op = 4'd3; i_addr = 8'h40; i_region = 1'b0; i_op_valid = 1'b1;
        @(negedge clk);
        i_op_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("erase_active", 32'(o_mem_erase), 32'd1);
        #2 rst_async = 1'b1;
        #1;
        check("rst_mid_erase", 32'(o_mem_erase), 32'd0);
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        check("rst_mid_ce", 32'(o_mem_ce), 32'd0);
        exp_data = 8'h00;
        @(negedge clk);
        rst_async = 1'b0;
        vcount = 0;
        repeat (20) begin
            @(negedge clk);
            vcount += int'(o_valid);
        end
        check("rst_no_valid", 32'(vcount), 32'd0);
        run_op(4'd1, 8'h05, 8'h00, 1'b0, 1'b0);

        // Random requests: mixed legal/illegal ops, ranges and regions
        for (int t = 0; t < 30; t++) begin
            logic [3:0] rop;
            int         sel;
            sel = int'($urandom_range(0, 9));
            rop = (sel < 4) ? 4'd1 : (sel < 6) ? 4'd2 : (sel == 6) ? 4'd3
                : (sel == 7) ? 4'd4 : (sel == 8) ? 4'd0 : 4'(8 + $urandom_range(0, 7));
            run_op(rop, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
